// File: rtl/rename_dispatch.sv
// rename_dispatch: register renaming with free list, ROB pointer allocation and one-cycle dispatch to IQ/LSQ.
//   CLK/RESET (async active-low), FREEZE global stall
//   dec_*      : decode handshake and instruction fields
//   *_full_IN  : downstream back-pressure
//   free_*_IN  : committed physical register returned to the free list
//   push_*_OUT / *_Data_OUT : registered dispatch to LSQ or IQ
//   fl_overflow_OUT : sticky free-list overflow
module rename_dispatch #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int FL_DEPTH  = 32,
  parameter int ROBP_BITS = 6,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int FW = $clog2(FL_DEPTH)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           FREEZE,
  input  logic                           dec_valid_IN,
  output logic                           dec_ready_OUT,
  input  logic [31:0]                    dec_instr_IN,
  input  logic [5:0]                     dec_op_IN,
  input  logic [15:0]                    dec_imm_IN,
  input  logic [AW-1:0]                  dec_src1_IN,
  input  logic [AW-1:0]                  dec_src2_IN,
  input  logic [AW-1:0]                  dec_dst_IN,
  input  logic                           dec_has_dst_IN,
  input  logic                           dec_is_mem_IN,
  input  logic                           rob_full_IN,
  input  logic                           LSQ_full_IN,
  input  logic                           IQ_full_IN,
  input  logic                           free_valid_IN,
  input  logic [PW-1:0]                  free_preg_IN,
  output logic                           push_LSQ_OUT,
  output logic [2*PW+ROBP_BITS+53:0]     LSQ_Data_OUT,
  output logic                           push_IQ_OUT,
  output logic [3*PW+ROBP_BITS+39:0]     IQ_Data_OUT,
  output logic                           fl_overflow_OUT
);
  logic [PW-1:0]        map_q [ARCH_REGS];
  logic [PW-1:0]        fl_q  [FL_DEPTH];
  logic [FW-1:0]        head_q, tail_q;
  logic [FW:0]          count_q;
  logic [ROBP_BITS-1:0] robp_q;
  logic                 accept, alloc, fl_full, push_ok;
  logic [PW-1:0]        sr1, sr2, dr;

  assign dec_ready_OUT = !FREEZE && !rob_full_IN && !LSQ_full_IN && !IQ_full_IN && count_q != '0;
  assign accept  = dec_valid_IN && dec_ready_OUT;
  assign alloc   = accept && dec_has_dst_IN && dec_dst_IN != '0;
  assign fl_full = count_q == (FW+1)'(FL_DEPTH);
  // a return into a full list is dropped; the free count never counts it
  assign push_ok = free_valid_IN && !fl_full;
  // sources read the map before this instruction's own destination update
  assign sr1 = map_q[dec_src1_IN];
  assign sr2 = map_q[dec_src2_IN];
  assign dr  = alloc ? fl_q[head_q] : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(ARCH_REGS + i);
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= (FW+1)'(FL_DEPTH);
      robp_q          <= '0;
      push_LSQ_OUT    <= 1'b0;
      push_IQ_OUT     <= 1'b0;
      LSQ_Data_OUT    <= '0;
      IQ_Data_OUT     <= '0;
      fl_overflow_OUT <= 1'b0;
    end else if (!FREEZE) begin
      if (alloc) begin
        map_q[dec_dst_IN] <= dr;
        head_q            <= head_q + 1'b1;
      end
      if (push_ok) begin
        fl_q[tail_q] <= free_preg_IN;
        tail_q       <= tail_q + 1'b1;
      end
      count_q <= count_q + (FW+1)'(push_ok) - (FW+1)'(alloc);
      if (free_valid_IN && fl_full) fl_overflow_OUT <= 1'b1;
      if (accept) robp_q <= robp_q + 1'b1;
      push_LSQ_OUT <= accept && dec_is_mem_IN;
      push_IQ_OUT  <= accept && !dec_is_mem_IN;
      if (accept && dec_is_mem_IN)
        LSQ_Data_OUT <= {dr, sr1, dec_imm_IN, dec_op_IN, robp_q, dec_instr_IN};
      if (accept && !dec_is_mem_IN)
        IQ_Data_OUT <= {dr, 1'b0, sr2, 1'b0, sr1, dec_op_IN, robp_q, dec_instr_IN};
    end
  end
endmodule

// File: tb/tb_rename_dispatch.sv
// tb_rename_dispatch: randomized and directed checks of rename_dispatch against a queue-based reference model.
module tb_rename_dispatch;
  logic        CLK = 1'b0, RESET = 1'b0, FREEZE;
  logic        dec_valid_IN, dec_ready_OUT, dec_has_dst_IN, dec_is_mem_IN;
  logic [31:0] dec_instr_IN;
  logic [5:0]  dec_op_IN;
  logic [15:0] dec_imm_IN;
  logic [4:0]  dec_src1_IN, dec_src2_IN, dec_dst_IN;
  logic        rob_full_IN, LSQ_full_IN, IQ_full_IN, free_valid_IN;
  logic [5:0]  free_preg_IN;
  logic        push_LSQ_OUT, push_IQ_OUT, fl_overflow_OUT;
  logic [71:0] LSQ_Data_OUT;
  logic [63:0] IQ_Data_OUT;

  rename_dispatch dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .dec_valid_IN(dec_valid_IN), .dec_ready_OUT(dec_ready_OUT),
    .dec_instr_IN(dec_instr_IN), .dec_op_IN(dec_op_IN), .dec_imm_IN(dec_imm_IN),
    .dec_src1_IN(dec_src1_IN), .dec_src2_IN(dec_src2_IN), .dec_dst_IN(dec_dst_IN),
    .dec_has_dst_IN(dec_has_dst_IN), .dec_is_mem_IN(dec_is_mem_IN),
    .rob_full_IN(rob_full_IN), .LSQ_full_IN(LSQ_full_IN), .IQ_full_IN(IQ_full_IN),
    .free_valid_IN(free_valid_IN), .free_preg_IN(free_preg_IN),
    .push_LSQ_OUT(push_LSQ_OUT), .LSQ_Data_OUT(LSQ_Data_OUT),
    .push_IQ_OUT(push_IQ_OUT), .IQ_Data_OUT(IQ_Data_OUT),
    .fl_overflow_OUT(fl_overflow_OUT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;

  // reference model: architectural map, free list as a FIFO queue, pool of retired pregs
  logic [5:0]  map_m [32];
  logic [5:0]  fl_m [$];
  logic [5:0]  pend [$];
  int          robp_m;
  logic        e_piq, e_plsq, e_ovf;
  logic [63:0] e_iq;
  logic [71:0] e_lsq;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) map_m[i] = 6'(i);
    fl_m = {};
    pend = {};
    for (int i = 32; i < 64; i++) fl_m.push_back(6'(i));
    robp_m = 0;
    {e_piq, e_plsq, e_ovf, e_iq, e_lsq} = '0;
  endtask

  function automatic logic exp_ready();
    return !FREEZE && !rob_full_IN && !LSQ_full_IN && !IQ_full_IN && fl_m.size() != 0;
  endfunction

  task automatic model_edge();
    logic       acc, full;
    logic [5:0] s1, s2, d, rp;
    if (FREEZE) return;
    acc  = dec_valid_IN && exp_ready();
    full = fl_m.size() == 32;
    e_piq  = acc && !dec_is_mem_IN;
    e_plsq = acc && dec_is_mem_IN;
    if (acc) begin
      s1 = map_m[dec_src1_IN];
      s2 = map_m[dec_src2_IN];
      d  = 6'd0;
      rp = 6'(robp_m);
      if (dec_has_dst_IN && dec_dst_IN != 5'd0) begin
        d = fl_m.pop_front();
        pend.push_back(map_m[dec_dst_IN]);
        map_m[dec_dst_IN] = d;
      end
      if (dec_is_mem_IN) e_lsq = {d, s1, dec_imm_IN, dec_op_IN, rp, dec_instr_IN};
      else e_iq = {d, 1'b0, s2, 1'b0, s1, dec_op_IN, rp, dec_instr_IN};
      robp_m = (robp_m + 1) % 64;
    end
    if (free_valid_IN) begin
      if (full) e_ovf = 1'b1;
      else fl_m.push_back(free_preg_IN);
    end
  endtask

  task automatic idle();
    {FREEZE, dec_valid_IN, dec_has_dst_IN, dec_is_mem_IN, rob_full_IN, LSQ_full_IN, IQ_full_IN, free_valid_IN} = '0;
    {dec_instr_IN, dec_op_IN, dec_imm_IN, dec_src1_IN, dec_src2_IN, dec_dst_IN, free_preg_IN} = '0;
  endtask

  task automatic instr(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic hd, input logic mem);
    dec_valid_IN = 1'b1;
    dec_dst_IN = d; dec_src1_IN = s1; dec_src2_IN = s2;
    dec_has_dst_IN = hd; dec_is_mem_IN = mem;
    dec_instr_IN = $urandom; dec_op_IN = 6'($urandom); dec_imm_IN = 16'($urandom);
  endtask

  task automatic step();
    #1;
    chk("ready", 72'(dec_ready_OUT), 72'(exp_ready()));
    @(posedge CLK);
    model_edge();
    #1;
    chk("push_iq", 72'(push_IQ_OUT), 72'(e_piq));
    chk("push_lsq", 72'(push_LSQ_OUT), 72'(e_plsq));
    chk("iq_data", 72'(IQ_Data_OUT), 72'(e_iq));
    chk("lsq_data", LSQ_Data_OUT, e_lsq);
    chk("overflow", 72'(fl_overflow_OUT), 72'(e_ovf));
    idle();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #1;
    chk("rst_piq", 72'(push_IQ_OUT), 72'(0));
    chk("rst_plsq", 72'(push_LSQ_OUT), 72'(0));
    chk("rst_iq_data", 72'(IQ_Data_OUT), 72'(0));
    chk("rst_lsq_data", LSQ_Data_OUT, 72'(0));
    chk("rst_ovf", 72'(fl_overflow_OUT), 72'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    do_reset();
    chk("rst_ready", 72'(dec_ready_OUT), 72'(1));

    // single ALU op r3 <= r1 + r2
    instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
    step();
    chk("alu_dr", 72'(IQ_Data_OUT[63:58]), 72'(32));
    chk("alu_sr1", 72'(IQ_Data_OUT[49:44]), 72'(1));
    chk("alu_sr2", 72'(IQ_Data_OUT[56:51]), 72'(2));
    chk("alu_robp", 72'(IQ_Data_OUT[37:32]), 72'(0));
    step();
    chk("strobe_drop", 72'(push_IQ_OUT), 72'(0));

    // back-to-back dependency chain and a load
    do_reset();
    instr(5'd5, 5'd5, 5'd5, 1'b1, 1'b0); step();
    chk("b2b1_dr", 72'(IQ_Data_OUT[63:58]), 72'(32));
    chk("b2b1_sr1", 72'(IQ_Data_OUT[49:44]), 72'(5));
    instr(5'd6, 5'd5, 5'd0, 1'b1, 1'b0); step();
    chk("b2b2_dr", 72'(IQ_Data_OUT[63:58]), 72'(33));
    chk("b2b2_sr1", 72'(IQ_Data_OUT[49:44]), 72'(32));
    chk("b2b2_sr2", 72'(IQ_Data_OUT[56:51]), 72'(0));
    instr(5'd7, 5'd6, 5'd0, 1'b1, 1'b1); step();
    chk("ld_push", 72'(push_LSQ_OUT), 72'(1));
    chk("ld_dr", 72'(LSQ_Data_OUT[71:66]), 72'(34));
    chk("ld_sr", 72'(LSQ_Data_OUT[65:60]), 72'(33));
    instr(5'd0, 5'd1, 5'd0, 1'b1, 1'b0); step();
    chk("r0_dr", 72'(IQ_Data_OUT[63:58]), 72'(0));

    // exhaust the free list, then return p3 with a request pending
    do_reset();
    for (int i = 0; i < 32; i++) begin
      instr(5'(1 + i % 31), 5'($urandom), 5'($urandom), 1'b1, i[0]);
      step();
    end
    dec_valid_IN = 1'b1;
    #1 chk("empty_ready", 72'(dec_ready_OUT), 72'(0));
    instr(5'd9, 5'd1, 5'd2, 1'b1, 1'b0);
    free_valid_IN = 1'b1; free_preg_IN = 6'd3;
    step();
    chk("nobypass", 72'(push_IQ_OUT), 72'(0));
    chk("refill_ready", 72'(dec_ready_OUT), 72'(1));
    instr(5'd9, 5'd1, 5'd2, 1'b1, 1'b0); step();
    chk("refill_dr", 72'(IQ_Data_OUT[63:58]), 72'(3));

    // each stall source blocks an accept, then a normal accept follows
    do_reset();
    for (int k = 0; k < 4; k++) begin
      instr(5'(1 + k), 5'd1, 5'd2, 1'b1, k[0]);
      FREEZE = (k == 0); rob_full_IN = (k == 1); LSQ_full_IN = (k == 2); IQ_full_IN = (k == 3);
      step();
      chk("stall_noacc", 72'(push_IQ_OUT | push_LSQ_OUT), 72'(0));
      instr(5'(1 + k), 5'd1, 5'd2, 1'b1, 1'b0); step();
    end
    chk("stall_robp", 72'(IQ_Data_OUT[37:32]), 72'(3));

    // freeze holds strobes and drops returns
    instr(5'd4, 5'd4, 5'd4, 1'b1, 1'b1); step();
    FREEZE = 1'b1; free_valid_IN = 1'b1; free_preg_IN = 6'd4; step();
    chk("freeze_hold", 72'(push_LSQ_OUT), 72'(1));

    // overflow on a return into a full list, cleared by async reset
    do_reset();
    free_valid_IN = 1'b1; free_preg_IN = 6'd9; step();
    step();
    chk("ovf_sticky", 72'(fl_overflow_OUT), 72'(1));
    #2 RESET = 1'b0;
    #1 chk("ovf_async_clr", 72'(fl_overflow_OUT), 72'(0));
    model_reset();
    @(posedge CLK); #1 RESET = 1'b1;

    // reset while a push is registered
    instr(5'd2, 5'd3, 5'd4, 1'b1, 1'b0); step();
    RESET = 1'b0;
    #1 chk("midrst_push", 72'(push_IQ_OUT), 72'(0));
    model_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    instr(5'd2, 5'd3, 5'd4, 1'b1, 1'b0); step();
    chk("midrst_dr", 72'(IQ_Data_OUT[63:58]), 72'(32));
    chk("midrst_robp", 72'(IQ_Data_OUT[37:32]), 72'(0));

    // randomized traffic with returns drawn from retired pregs
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom % 4 != 0)
        instr(5'($urandom), 5'($urandom), 5'($urandom), $urandom % 4 != 0, $urandom % 3 == 0);
      FREEZE = $urandom % 12 == 0;
      rob_full_IN = $urandom % 12 == 0;
      LSQ_full_IN = $urandom % 12 == 0;
      IQ_full_IN = $urandom % 12 == 0;
      if (pend.size() != 0 && $urandom % 2 == 0) begin
        int idx;
        idx = int'($urandom % pend.size());
        free_valid_IN = 1'b1;
        free_preg_IN = pend[idx];
        pend.delete(idx);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
